mdu_ctrl: RTL and testbench
===========================

// Module: mdu_ctrl
// PURPOSE
//  Multi-cycle multiply/divide controller with HI/LO registers for the pipelined MIPS CPU.
//  - Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage.
//  - Counts out a fixed latency, then commits HI/LO.
//  - Raises busy so the hazard unit stalls any later MD-class instruction (MFHI/MFLO/MT*/MUL*/DIV*).
//  - Honours the exception/interrupt kill from CP0, so a killed instruction never touches HI/LO.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk     in   1   system clock, rising edge
//  reset   in   1   asynchronous, active-high; clears all state
//  start   in   1   EX-stage MD instruction valid this cycle
//  op      in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 no-op
//  kill    in   1   CP0 exception/interrupt flush; suppresses start this cycle
//  a       in   32  rs operand
//  b       in   32  rt operand
//  busy    out  1   operation in flight (registered)
//  hi      out  32  HI register
//  lo      out  32  LO register
// BEHAVIOUR
//  Reset (async, any time, incl. mid-operation)
//   - busy=0, hi=0, lo=0, state=IDLE, counter=0, latched operands discarded.
//  States and transitions
//   - IDLE -> RUN on edge where start&!kill and op is 0-3.
//     - a, b and op are latched on that edge.
//     - counter := N-1 (N = MULT_CYCLES or DIV_CYCLES).
//   - RUN with counter != 0: counter decrements each edge.
//   - RUN with counter == 0: hi/lo committed on that edge; busy drops; return to IDLE.
//  Latency and timing
//   - Start accepted at edge t: busy=1 for exactly N cycles, (t, t+N].
//   - New hi/lo and busy=0 are visible together after edge t+N.
//   - Back-to-back: a new start is accepted on the same edge where busy falls only if the
//     controller is IDLE at that edge; it is not (still RUN), so the earliest next accept is t+N+1.
//  Direct writes
//   - MTHI/MTLO with start&!kill in IDLE: hi (or lo) := a on that edge. Single cycle; busy stays 0.
//  Ignored requests
//   - Any start while busy=1: no effect on the operation in flight. The hazard unit guarantees
//     no such start.
//   - kill=1: start ignored, regardless of op.
//   - op 6-7: no-op.
//  Arithmetic
//   - MULT: {hi,lo} := signed 64-bit product.
//   - MULTU: {hi,lo} := unsigned 64-bit product.
//   - DIV: lo := quotient truncated toward zero; hi := remainder with the sign of the dividend.
//     0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
//   - DIVU: unsigned quotient and remainder.
//   - b==0 on DIV/DIVU: full DIV_CYCLES busy, then hi/lo unchanged.
//  Structure
//   - Result may be computed combinationally from latched operands; only the commit timing is
//     architectural.
//   - hi, lo and busy are driven straight from flops (no combinational path from inputs).
// TESTING
//  - Reset: reset=1 mid-RUN (3rd busy cycle of a DIV) -> busy, hi, lo = 0 immediately, without
//    waiting for a clock edge; after release, stays IDLE.
//  - MULT a=0xFFFFFFFD, b=5 -> busy high 5 cycles -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  - MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
//  - DIV a=0xFFFFFFF9 (-7), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//    Then DIVU 7/0 -> busy 10 cycles, hi/lo unchanged.
//  - MTHI a=0x12345678 while idle -> hi=0x12345678 next edge, busy never asserts.
//    MTLO issued while busy -> lo unaffected.
//  - start=1, op=MULT, kill=1 -> busy stays 0, hi/lo unchanged.
//    Overflow DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller owning the HI/LO registers.
//   An accepted MULT/MULTU/DIV/DIVU latches its operands, stays busy for a
//   fixed number of cycles and then commits HI/LO. MTHI/MTLO write directly
//   in one cycle. A CP0 kill suppresses the start in the same cycle.
// Ports:
//   clk   in   rising-edge clock
//   reset in   asynchronous active-high reset, clears all state
//   start in   EX-stage MD instruction valid
//   op    in   [2:0] 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   kill  in   exception/interrupt flush, suppresses start
//   a, b  in   [31:0] rs / rt operands
//   busy  out  operation in flight (flop output)
//   hi,lo out  [31:0] HI / LO registers (flop outputs)
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        kill,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          busy_q, busy_d;

  // Results are formed combinationally from the latched operands; only the
  // commit edge is architectural.
  logic [63:0] prod_s, prod_u;
  logic        div_signed;
  logic [31:0] dvd, dvs_mag, dvs, uq, ur, quo, rem;

  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};

  // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly
  // to 0x80000000 instead of relying on simulator overflow behaviour.
  assign div_signed = ~op_q[0];
  assign dvd     = (div_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
  assign dvs_mag = (div_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
  // Divide-by-zero result is discarded; a dummy divisor keeps the math defined.
  assign dvs     = (b_q == 32'd0) ? 32'd1 : dvs_mag;
  assign uq      = dvd / dvs;
  assign ur      = dvd % dvs;
  assign quo     = (div_signed && (a_q[31] ^ b_q[31])) ? (~uq + 32'd1) : uq;
  assign rem     = (div_signed && a_q[31]) ? (~ur + 32'd1) : ur;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              state_d = RUN;
              op_d    = op[1:0];
              a_d     = a;
              b_d     = b;
              cnt_d   = op[1] ? DIV_LAST : MULT_LAST;
            end
            3'd4:    hi_d = a;
            3'd5:    lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Starts are ignored here; the hazard unit never issues one.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
          case (op_q)
            2'd0:    {hi_d, lo_d} = prod_s;
            2'd1:    {hi_d, lo_d} = prod_u;
            default: begin
              if (b_q != 32'd0) begin
                lo_d = quo;
                hi_d = rem;
              end
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        kill;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .kill(kill),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one MD operation, optionally poking an MTLO during its first busy
  // cycle, then count busy cycles and compare against the scoreboard entry.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input int n, input bit inject_mtlo);
    exp_t e;
    int   cnt;
    e.tag = tag; e.hi = eh; e.lo = el; e.cycles = n;
    sb.push_back(e);
    start = 1'b1; op = o; a = av; b = bv;
    tick();
    start = 1'b0; op = 3'd7; a = 32'h0; b = 32'h0;
    if (inject_mtlo) begin
      start = 1'b1; op = 3'd5; a = 32'hDEADBEEF;
    end
    cnt = 0;
    while (busy === 1'b1 && cnt < 50) begin
      cnt++;
      tick();
      start = 1'b0; op = 3'd7; a = 32'h0;
    end
    e = sb.pop_front();
    check({e.tag, "_busy_cycles"}, 32'(cnt), 32'(e.cycles));
    check({e.tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({e.tag, "_hi"}, hi, e.hi);
    check({e.tag, "_lo"}, lo, e.lo);
    $display("txn %s op=%0d a=%h b=%h busy_cycles=%0d hi=%h lo=%h", tag, o, av, bv, cnt, hi, lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd7; kill = 1'b0; a = 32'h0; b = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    $display("txn reset busy=%b hi=%h lo=%h", busy, hi, lo);

    run_op("mult",  3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, 1'b0);
    // Back-to-back: issued on the edge right after busy drops.
    run_op("multu_mtlo_busy", 3'd1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, 1'b1);
    run_op("div",   3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0);
    run_op("divu_by0", 3'd3, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0);

    // MTHI while idle: single-cycle write, busy never asserts.
    start = 1'b1; op = 3'd4; a = 32'h12345678;
    tick();
    start = 1'b0; op = 3'd7; a = 32'h0;
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_lo", lo, 32'hFFFFFFFD);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    tick();
    check("mthi_busy2", {31'd0, busy}, 32'd0);
    $display("txn mthi hi=%h lo=%h busy=%b", hi, lo, busy);

    // Killed MULT: nothing happens.
    start = 1'b1; op = 3'd0; kill = 1'b1; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0; kill = 1'b0; op = 3'd7;
    check("kill_busy", {31'd0, busy}, 32'd0);
    tick();
    check("kill_busy2", {31'd0, busy}, 32'd0);
    check("kill_hi", hi, 32'h12345678);
    check("kill_lo", lo, 32'hFFFFFFFD);
    $display("txn kill busy=%b hi=%h lo=%h", busy, hi, lo);

    // Reserved op: no-op.
    start = 1'b1; op = 3'd6; a = 32'hA5A5A5A5;
    tick();
    start = 1'b0; op = 3'd7;
    check("nop_busy", {31'd0, busy}, 32'd0);
    check("nop_hi", hi, 32'h12345678);
    $display("txn nop busy=%b hi=%h lo=%h", busy, hi, lo);

    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 1'b0);
    run_op("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b0);
    run_op("div_neg_divisor", 3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10, 1'b0);

    // Asynchronous reset during the 3rd busy cycle of a DIV.
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
    tick();
    start = 1'b0; op = 3'd7;
    tick();
    tick();
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    check("async_reset_hi", hi, 32'd0);
    check("async_reset_lo", lo, 32'd0);
    $display("txn async_reset busy=%b hi=%h lo=%h", busy, hi, lo);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    check("post_reset_hi", hi, 32'd0);
    check("post_reset_lo", lo, 32'd0);
    $display("txn post_reset busy=%b hi=%h lo=%h", busy, hi, lo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
